// File: rtl/crc_serial_pkg.sv
// Shared types and well-known polynomials for the serial CRC engine.
// Imported by crc_serial_step and crc_serial_engine.
package crc_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [7:0]  DOW_CRC8_POLY    = 8'h31;
  localparam logic [15:0] MAXIM_CRC16_POLY = 16'h8005;

endpackage

// File: rtl/crc_serial_step.sv
// One-bit combinational CRC update, LSB-first (reflected) or MSB-first.
// The reflected form uses the bit-reversed polynomial.
module crc_serial_step
  import crc_serial_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(DOW_CRC8_POLY),
  parameter bit               REFLECT = 1'b1
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic fb;

  if (REFLECT) begin : g_ref
    logic [CRC_W-1:0] poly_rev;
    for (genvar i = 0; i < CRC_W; i++) begin : g_rev
      assign poly_rev[i] = POLY[CRC_W-1-i];
    end
    assign fb    = crc_i[0] ^ bit_i;
    assign crc_o = (crc_i >> 1) ^ (fb ? poly_rev : '0);
  end else begin : g_msb
    assign fb    = crc_i[CRC_W-1] ^ bit_i;
    assign crc_o = (crc_i << 1) ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: IDLE -> RUN -> DONE, one bit per valid cycle.
// Define CRC_SERIAL_CHECK_EN to build the zero-residue crc_ok flag.
module crc_serial_engine
  import crc_serial_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(DOW_CRC8_POLY),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOROUT  = '0,
  parameter bit               REFLECT = 1'b1,
  parameter int               LEN_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             done,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_ok
);

  state_e           state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [LEN_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [CRC_W-1:0] out_q;

  crc_serial_step #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .REFLECT(REFLECT)
  ) u_step (
    .crc_i(crc_q),
    .bit_i(bit_in),
    .crc_o(crc_d)
  );

`ifdef CRC_SERIAL_CHECK_EN
  logic ok_q;
  assign crc_ok = ok_q;
`else
  assign crc_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
`ifdef CRC_SERIAL_CHECK_EN
      ok_q    <= 1'b0;
`endif
    end else if (start) begin
      // Accepted from every state; in RUN this is a restart.
      crc_q <= INIT;
      cnt_q <= len;
      if (len == '0) begin
        state_q <= ST_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        out_q   <= INIT ^ XOROUT;
`ifdef CRC_SERIAL_CHECK_EN
        ok_q    <= (INIT == '0);
`endif
      end else begin
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
        end
        ST_RUN: begin
          if (bit_valid) begin
            crc_q <= crc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              out_q   <= crc_d ^ XOROUT;
`ifdef CRC_SERIAL_CHECK_EN
              ok_q    <= (crc_d == '0);
`endif
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign crc_out = out_q;

endmodule
